// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter.
//   arb_state_t          : arbiter FSM states (IDLE, GRANT)
//   DIR_LEFT / DIR_RIGHT : values of the mode input (0 = rotate left, 1 = rotate right)
//   onehot2bin           : index of the set bit of a one-hot vector (0 when none is set)
//   is_onehot            : 1 when exactly one bit of the vector is set
// Both helpers take a MAX_N-wide vector; callers zero-extend narrower vectors.
package ring_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int MAX_N = 64;

    function automatic int onehot2bin(input logic [MAX_N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ring_token_reg.sv
// One-hot priority token register for the ring arbiter.
// Ports:
//   clock    in  : clock, state changes on posedge
//   reset    in  : asynchronous, active-low; token returns to bit 0
//   load_en  in  : load token from load (caller guarantees load is one-hot)
//   load     in  : new token value
//   adv_en   in  : advance token one position past adv_from
//   adv_from in  : one-hot position to advance from (the releasing owner)
//   mode     in  : DIR_LEFT advances toward higher index, DIR_RIGHT toward lower
//   token    out : current one-hot token
module ring_token_reg
    import ring_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_en,
    input  logic [N-1:0] load,
    input  logic         adv_en,
    input  logic [N-1:0] adv_from,
    input  logic         mode,
    output logic [N-1:0] token
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            token <= {{(N-1){1'b0}}, 1'b1};
        end else if (adv_en) begin
            // Rotating the one-hot owner by one lands on the next position in the ring.
            if (mode == DIR_RIGHT) token <= {adv_from[0], adv_from[N-1:1]};
            else                   token <= {adv_from[N-2:0], adv_from[N-1]};
        end else if (load_en) begin
            token <= load;
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter sharing one downstream resource among N requesters.
// Priority is a one-hot ring token; the search starts at the token and walks
// upward (mode=0) or downward (mode=1) with wrap-around. Grant is registered
// and sticky until the owner drops its request.
// Optional feature: define RING_TOKEN_ARBITER_TIMEOUT_EN to force a revoke after
// MAX_HOLD consecutive grant cycles.
// Ports:
//   clock       in  : clock
//   reset       in  : asynchronous, active-low
//   req         in  : per-requester request, level-sensitive
//   mode        in  : 1 = rotate right (lower index), 0 = rotate left
//   load_en     in  : load token from load (IDLE only, load must be one-hot)
//   load        in  : new token value
//   grant       out : one-hot grant, registered
//   grant_valid out : |grant
//   grant_id    out : binary index of the owner, 0 when no grant
//   token       out : current priority token
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    input  logic                 load_en,
    input  logic [N-1:0]         load,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         token
);

    localparam int IDW = $clog2(N);

    arb_state_t         state;
    logic [MAX_N-1:0]   token_ext;
    logic [MAX_N-1:0]   load_ext;
    logic               load_take;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic               hold_expired;
    logic               release_now;

    assign token_ext = {{(MAX_N-N){1'b0}}, token};
    assign load_ext  = {{(MAX_N-N){1'b0}}, load};

    // A malformed load is dropped so arbitration can proceed in the same cycle.
    assign load_take = (state == IDLE) && load_en && is_onehot(load_ext);

    // Masked priority search: first set request starting at the token position.
    always_comb begin
        int pos;
        int cand;
        logic [IDW-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = onehot2bin(token_ext);
        cand      = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == DIR_LEFT) cand = (pos + i) % N;
            else                  cand = (pos - i + N) % N;
            idx = IDW'(cand);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // Counts grant cycles; reads 1 during the first cycle the grant is visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= (!load_take && win_found) ? HOLD_W'(1) : '0;
        end else if (release_now) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD));
`else
    assign hold_expired = 1'b0;
`endif

    assign release_now = (state == GRANT) && (!req[grant_id] || hold_expired);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!load_take && win_found) begin
                        grant    <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        grant_id <= win_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Releasing always passes through IDLE, so grants never run back to back.
                    if (release_now) begin
                        grant    <= '0;
                        grant_id <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                end
            endcase
        end
    end

    assign grant_valid = |grant;

    ring_token_reg #(.N(N)) u_token (
        .clock    (clock),
        .reset    (reset),
        .load_en  (load_take),
        .load     (load),
        .adv_en   (release_now),
        .adv_from (grant),
        .mode     (mode),
        .token    (token)
    );

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter (N=4, MAX_HOLD=8).
// Build with RING_TOKEN_ARBITER_TIMEOUT_EN defined to exercise the forced revoke.
module tb_ring_token_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic         mode;
    logic         load_en;
    logic [N-1:0] load;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [N-1:0] token;

    int errors = 0;
    int checks = 0;

    ring_token_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .mode        (mode),
        .load_en     (load_en),
        .load        (load),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .token       (token)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        req     = '0;
        mode    = 1'b0;
        load_en = 1'b0;
        load    = '0;
        step();
        step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_id",    32'(grant_id), 32'h0);
        check("rst_token", 32'(token), 32'h1);
        reset = 1'b1;

        // Token 0001, upward search from 0 finds requester 1.
        req  = 4'b0110;
        mode = 1'b0;
        step();
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_id",    32'(grant_id), 32'h1);
        check("t1_valid", 32'(grant_valid), 32'h1);
        req = 4'b0000;
        step();
        check("t1_rel_grant", 32'(grant), 32'h0);
        check("t1_rel_valid", 32'(grant_valid), 32'h0);
        check("t1_rel_token", 32'(token), 32'h4);

        // Token 0100, downward search: 2 idle, 1 wins.
        mode = 1'b1;
        req  = 4'b1011;
        step();
        check("t2_grant", 32'(grant), 32'h2);
        check("t2_id",    32'(grant_id), 32'h1);
        req = 4'b0000;
        step();
        check("t2_rel_grant", 32'(grant), 32'h0);
        check("t2_rel_token", 32'(token), 32'h1);

        // Non-one-hot load is ignored.
        mode    = 1'b0;
        load_en = 1'b1;
        load    = 4'b0011;
        step();
        check("ld_bad_token", 32'(token), 32'h1);
        check("ld_bad_grant", 32'(grant), 32'h0);
        // One-hot load taken; pending request does not get a grant this cycle.
        load = 4'b1000;
        req  = 4'b0001;
        step();
        check("ld_token", 32'(token), 32'h8);
        check("ld_grant", 32'(grant), 32'h0);
        load_en = 1'b0;
        load    = 4'b0000;
        // Wrap: token 1000, upward search wraps 3 -> 0.
        step();
        check("wrap_grant", 32'(grant), 32'h1);
        check("wrap_id",    32'(grant_id), 32'h0);
        req = 4'b0000;
        step();
        check("wrap_rel_grant", 32'(grant), 32'h0);
        check("wrap_rel_token", 32'(token), 32'h2);

        // Malformed load with a request pending: arbitration proceeds from token 0010.
        load_en = 1'b1;
        load    = 4'b0101;
        req     = 4'b0100;
        step();
        check("ldarb_grant", 32'(grant), 32'h4);
        check("ldarb_id",    32'(grant_id), 32'h2);
        check("ldarb_token", 32'(token), 32'h2);

        // Hold phase: a valid load during GRANT is ignored.
        load = 4'b0001;
        for (int k = 2; k <= 8; k++) begin
            if (k == 5) begin
                check("grant_ld_token", 32'(token), 32'h2);
                load_en = 1'b0;
                load    = 4'b0000;
            end
            step();
            check($sformatf("hold_grant_%0d", k), 32'(grant), 32'h4);
        end

`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
        // Eight grant cycles seen; forced revoke next, then one IDLE cycle.
        step();
        check("to_rev_grant", 32'(grant), 32'h0);
        check("to_rev_token", 32'(token), 32'h8);
        step();
        check("to_regrant",    32'(grant), 32'h4);
        check("to_regrant_id", 32'(grant_id), 32'h2);
`else
        // Other requests do not preempt the owner.
        req = 4'b1111;
        for (int k = 9; k <= 12; k++) begin
            step();
            check($sformatf("hold_grant_%0d", k), 32'(grant), 32'h4);
        end
        check("hold_id", 32'(grant_id), 32'h2);
`endif

        // Reset mid-grant acts without a clock edge.
        reset = 1'b0;
        #2;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_valid", 32'(grant_valid), 32'h0);
        check("arst_id",    32'(grant_id), 32'h0);
        check("arst_token", 32'(token), 32'h1);
        req = 4'b0000;
        step();
        reset = 1'b1;
        step();
        check("post_rst_grant", 32'(grant), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
